// File: rtl/i2c_byte_ctl.sv
// ---------------------------------------------------------------------------
// i2c_byte_ctl
//
// Byte-level command sequencer between the I2C host/register interface and
// the bit controller. One host transaction (optional START, one byte WRITE
// or READ, the ACK bit, optional STOP) is broken into single-bit commands.
// Data is shifted MSB-first; completion, received ACK and arbitration loss
// are reported back to the host.
//
// Build option: define I2C_BYTE_CMD_TIMEOUT_EN to add a per-command timeout
// (abort after timeout_i cycles without cmd_ack_i, pulsing tmo_o). Without
// it, timeout_i is ignored, tmo_o stays 0 and the block waits indefinitely.
//
// Ports
//   sysclk_i, rst_i         clock, asynchronous active-high reset
//   enable_i                core enable; low forces IDLE / NOP
//   start_i/stop_i/read_i/write_i, ack_in_i, din_i
//                           host command flags (held until cmd_ack_o),
//                           ACK to send after a READ, byte to send
//   timeout_i               command timeout limit (timeout build only)
//   dout_o, rxack_o         received byte, ACK sampled after a WRITE
//   cmd_ack_o, busy_o       transaction done/aborted pulse, busy flag
//   i2c_al_o, tmo_o         arbitration-loss / timeout pulses
//   cmd_o, bit_o            bit command and write bit to the bit controller
//   cmd_ack_i, arblost_i, bit_i
//                           bit controller handshake, arb loss, read bit
// ---------------------------------------------------------------------------
module i2c_byte_ctl #(
   parameter int TMO_W = 16
) (
   input  logic             sysclk_i,
   input  logic             rst_i,
   input  logic             enable_i,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             read_i,
   input  logic             write_i,
   input  logic             ack_in_i,
   input  logic [7:0]       din_i,
   input  logic [TMO_W-1:0] timeout_i,
   output logic [7:0]       dout_o,
   output logic             rxack_o,
   output logic             cmd_ack_o,
   output logic             busy_o,
   output logic             i2c_al_o,
   output logic             tmo_o,
   output logic [3:0]       cmd_o,
   output logic             bit_o,
   input  logic             cmd_ack_i,
   input  logic             arblost_i,
   input  logic             bit_i
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_WRITE = 3'd2;
   localparam logic [2:0] ST_READ  = 3'd3;
   localparam logic [2:0] ST_ACK   = 3'd4;
   localparam logic [2:0] ST_STOP  = 3'd5;
   localparam logic [2:0] ST_DONE  = 3'd6;

   localparam logic [3:0] CMD_NOP   = 4'b0000;
   localparam logic [3:0] CMD_START = 4'b0001;
   localparam logic [3:0] CMD_STOP  = 4'b0010;
   localparam logic [3:0] CMD_WRITE = 4'b0100;
   localparam logic [3:0] CMD_READ  = 4'b1000;

   logic [2:0] state_reg;
   logic [3:0] cmd_reg;
   logic       bit_reg;
   logic [7:0] shift_reg;
   logic [7:0] dout_reg;
   logic [2:0] cnt_reg;
   logic       stop_l_reg;
   logic       read_l_reg;
   logic       write_l_reg;
   logic       rxack_reg;
   logic       cmd_ack_reg;
   logic       busy_reg;
   logic       al_reg;
   logic       tmo_reg;

   logic go;
   logic tmo_hit;

   assign go = start_i | stop_i | read_i | write_i;

`ifdef I2C_BYTE_CMD_TIMEOUT_EN
   // Counts cycles spent waiting on the current bit command; cleared in
   // IDLE/DONE and whenever a command is acknowledged (cmd_o reloaded).
   logic [TMO_W-1:0] tmo_cnt_reg;
   logic [TMO_W-1:0] tmo_next;
   logic             waiting;

   assign waiting  = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
   assign tmo_next = tmo_cnt_reg + {{(TMO_W-1){1'b0}}, 1'b1};
   // Abort on the edge that would complete the timeout_i-th waiting cycle.
   assign tmo_hit  = waiting && !cmd_ack_i && (timeout_i != '0) &&
                     (tmo_next == timeout_i);

   always_ff @(posedge sysclk_i or posedge rst_i) begin
      if (rst_i) begin
         tmo_cnt_reg <= '0;
      end else if (!waiting || cmd_ack_i) begin
         tmo_cnt_reg <= '0;
      end else begin
         tmo_cnt_reg <= tmo_next;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = ^timeout_i;
   assign tmo_hit        = 1'b0;
`endif

   always_ff @(posedge sysclk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg   <= ST_IDLE;
         cmd_reg     <= CMD_NOP;
         bit_reg     <= 1'b0;
         shift_reg   <= 8'h00;
         dout_reg    <= 8'h00;
         cnt_reg     <= 3'd7;
         stop_l_reg  <= 1'b0;
         read_l_reg  <= 1'b0;
         write_l_reg <= 1'b0;
         rxack_reg   <= 1'b0;
         cmd_ack_reg <= 1'b0;
         busy_reg    <= 1'b0;
         al_reg      <= 1'b0;
         tmo_reg     <= 1'b0;
      end else begin
         // status pulses last exactly one cycle
         cmd_ack_reg <= 1'b0;
         al_reg      <= 1'b0;
         tmo_reg     <= 1'b0;

         if (!enable_i) begin
            // silent abort: no completion pulse, received data held
            state_reg <= ST_IDLE;
            cmd_reg   <= CMD_NOP;
            busy_reg  <= 1'b0;
            cnt_reg   <= 3'd7;
         end else if ((state_reg != ST_IDLE) && (arblost_i || tmo_hit)) begin
            // arbitration loss outranks a coincident cmd_ack_i and a timeout
            state_reg   <= ST_IDLE;
            cmd_reg     <= CMD_NOP;
            busy_reg    <= 1'b0;
            cnt_reg     <= 3'd7;
            cmd_ack_reg <= 1'b1;
            al_reg      <= arblost_i;
            tmo_reg     <= !arblost_i;
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  // cmd_ack_reg high means the host has not yet seen the
                  // completion of the previous transaction; its flags may
                  // still be asserted, so do not re-arm on them.
                  if (go && !cmd_ack_reg) begin
                     stop_l_reg  <= stop_i;
                     read_l_reg  <= read_i;
                     write_l_reg <= write_i;
                     shift_reg   <= din_i;
                     busy_reg    <= 1'b1;
                     cnt_reg     <= 3'd7;
                     if (start_i) begin
                        state_reg <= ST_START;
                        cmd_reg   <= CMD_START;
                     end else if (read_i) begin
                        state_reg <= ST_READ;
                        cmd_reg   <= CMD_READ;
                     end else if (write_i) begin
                        state_reg <= ST_WRITE;
                        cmd_reg   <= CMD_WRITE;
                        bit_reg   <= din_i[7];
                     end else begin
                        state_reg <= ST_STOP;
                        cmd_reg   <= CMD_STOP;
                     end
                  end
               end

               ST_START: begin
                  if (cmd_ack_i) begin
                     if (read_l_reg) begin
                        state_reg <= ST_READ;
                        cmd_reg   <= CMD_READ;
                     end else if (write_l_reg) begin
                        state_reg <= ST_WRITE;
                        cmd_reg   <= CMD_WRITE;
                        bit_reg   <= shift_reg[7];
                     end else if (stop_l_reg) begin
                        state_reg <= ST_STOP;
                        cmd_reg   <= CMD_STOP;
                     end else begin
                        state_reg <= ST_DONE;
                        cmd_reg   <= CMD_NOP;
                     end
                  end
               end

               ST_WRITE: begin
                  if (cmd_ack_i) begin
                     shift_reg <= {shift_reg[6:0], 1'b0};
                     bit_reg   <= shift_reg[6];
                     cnt_reg   <= cnt_reg - 3'd1;
                     if (cnt_reg == 3'd0) begin
                        // slave ACK is sampled with a READ bit command
                        state_reg <= ST_ACK;
                        cmd_reg   <= CMD_READ;
                     end
                  end
               end

               ST_READ: begin
                  if (cmd_ack_i) begin
                     shift_reg <= {shift_reg[6:0], bit_i};
                     // dout_o has its own register so a following WRITE's
                     // din_i load does not disturb the last received byte
                     dout_reg  <= {dout_reg[6:0], bit_i};
                     cnt_reg   <= cnt_reg - 3'd1;
                     if (cnt_reg == 3'd0) begin
                        // master ACK/NACK is driven with a WRITE bit command
                        state_reg <= ST_ACK;
                        cmd_reg   <= CMD_WRITE;
                        bit_reg   <= ack_in_i;
                     end
                  end
               end

               ST_ACK: begin
                  if (cmd_ack_i) begin
                     if (!read_l_reg) begin
                        rxack_reg <= bit_i;
                     end
                     if (stop_l_reg) begin
                        state_reg <= ST_STOP;
                        cmd_reg   <= CMD_STOP;
                     end else begin
                        state_reg <= ST_DONE;
                        cmd_reg   <= CMD_NOP;
                     end
                  end
               end

               ST_STOP: begin
                  if (cmd_ack_i) begin
                     state_reg <= ST_DONE;
                     cmd_reg   <= CMD_NOP;
                  end
               end

               ST_DONE: begin
                  state_reg   <= ST_IDLE;
                  cmd_reg     <= CMD_NOP;
                  cmd_ack_reg <= 1'b1;
                  busy_reg    <= 1'b0;
                  cnt_reg     <= 3'd7;
               end

               default: begin
                  state_reg <= ST_IDLE;
                  cmd_reg   <= CMD_NOP;
                  busy_reg  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign dout_o    = dout_reg;
   assign rxack_o   = rxack_reg;
   assign cmd_ack_o = cmd_ack_reg;
   assign busy_o    = busy_reg;
   assign i2c_al_o  = al_reg;
   assign tmo_o     = tmo_reg;
   assign cmd_o     = cmd_reg;
   assign bit_o     = bit_reg;

endmodule

// File: doc/i2c_byte_ctl.md
# i2c_byte_ctl

Byte-level command sequencer sitting between the I2C register/host interface and the bit controller. It accepts one host transaction (optional START, one byte WRITE or READ, an ACK bit, optional STOP) and breaks it into a series of single-bit commands to the bit controller. It shifts data MSB-first, captures or drives the ACK bit, and reports completion, the received ACK and arbitration loss back to the host.

## Interface
Parameters:
- `TMO_W`, 16: width of the command-timeout counter (only used when the timeout feature is compiled in).

Ports:
- `sysclk_i` in 1: system clock; all logic is on the rising edge.
- `rst_i` in 1: reset, asynchronous and active-high.
- `enable_i` in 1: core enable; low forces IDLE and `cmd_o`=NOP.
- `start_i`, `stop_i`, `read_i`, `write_i` in 1 each: host command flags, held until `cmd_ack_o`.
- `ack_in_i` in 1: ACK value to send after a READ (0 = ACK, 1 = NACK).
- `din_i` in 8: byte to transmit.
- `timeout_i` in TMO_W: timeout limit in `sysclk_i` cycles (timeout build only).
- `dout_o` out 8: received byte.
- `rxack_o` out 1: ACK bit sampled after a WRITE.
- `cmd_ack_o` out 1: one-cycle pulse when the transaction finishes or aborts.
- `busy_o` out 1: high while a transaction is in progress.
- `i2c_al_o` out 1: one-cycle pulse on arbitration loss.
- `tmo_o` out 1: one-cycle pulse on timeout (timeout build only).
- `cmd_o` out 4: bit command to the bit controller. Encoding: NOP=4'b0000, START=4'b0001, STOP=4'b0010, WRITE=4'b0100, READ=4'b1000.
- `bit_o` out 1: bit to drive for a WRITE command.
- `cmd_ack_i` in 1: bit controller finished the current bit command.
- `arblost_i` in 1: bit controller lost arbitration.
- `bit_i` in 1: bit sampled by the bit controller for a READ command.

## Operation
- States: IDLE, START, WRITE, READ, ACK, STOP, DONE.
- Reset values: state=IDLE, `cmd_o`=NOP, `bit_o`=0, shift register=0 (so `dout_o`=0), bit counter=7, all flag outputs 0.
- IDLE: when `enable_i` is high and `go` (start|stop|read|write) is high, latch the flags, load `din_i` into the shift register, set `busy_o`=1, then branch:
  - start → START;
  - else read → READ (read wins over write when both are set);
  - else write → WRITE;
  - else STOP.
- START: `cmd_o`=START. On `cmd_ack_i`: go to READ or WRITE if requested; else STOP if requested; else DONE.
- WRITE: `cmd_o`=WRITE, `bit_o`=shift[7].
  - On each `cmd_ack_i`: shift left and decrement the counter.
  - After the 8th ack (counter was 0), go to ACK with `cmd_o`=READ.
- READ: `cmd_o`=READ.
  - On each `cmd_ack_i`: shift = {shift[6:0], `bit_i`}.
  - After the 8th ack, go to ACK with `cmd_o`=WRITE and `bit_o`=`ack_in_i`.
- ACK: on `cmd_ack_i`, set `rxack_o`=`bit_i` (write transfer only; `rxack_o` is held on a read). Then go to STOP if stop was latched, else DONE.
- STOP: `cmd_o`=STOP; on `cmd_ack_i` go to DONE.
- DONE: `cmd_o`=NOP, `cmd_ack_o`=1 for one cycle, `busy_o` clears, reload counter=7, then IDLE.
- Host rule: the host clears its flags on the same edge it samples `cmd_ack_o`, so the next IDLE cycle sees `go`=0. The block does not re-arm on flags still held during DONE.
- Arbitration loss: `arblost_i` in any non-IDLE state gives, on the next edge:
  - state=IDLE, `cmd_o`=NOP, `busy_o`=0;
  - `i2c_al_o`=1 and `cmd_ack_o`=1 for one cycle.
  - `arblost_i` takes priority over a simultaneous `cmd_ack_i`.
- `enable_i` low in any state: next edge IDLE and `cmd_o`=NOP, with no `cmd_ack_o`. `dout_o` and `rxack_o` are held.

## Timing
- All outputs are registered.
- `cmd_o` changes only on the edge where `cmd_ack_i` is high, or on entering or leaving IDLE/DONE. Consecutive bit commands are back-to-back, with no NOP cycle between them.
- The first bit command appears on `cmd_o` 1 cycle after `go` is sampled in IDLE.
- `cmd_ack_o` comes 2 cycles after the final `cmd_ack_i`: one edge to enter DONE, then the pulse.
- `dout_o` is valid when `cmd_ack_o` is high and stays stable until the next READ bit shifts in.
- `cmd_ack_i` in IDLE or DONE is ignored.

## Configuration
- `I2C_BYTE_CMD_TIMEOUT_EN` defined:
  - A TMO_W-bit counter clears whenever `cmd_o` is loaded and counts while the block is in a non-IDLE state waiting for `cmd_ack_i`.
  - When the count reaches `timeout_i` (and `timeout_i`≠0), the block aborts exactly like an arbitration loss, but pulses `tmo_o` instead of `i2c_al_o`.
- Not defined: no counter is built, `timeout_i` is unused, `tmo_o` is tied to 0, and the block waits indefinitely.

## Test plan
- START + WRITE `din_i`=8'hA5 + STOP, bit model returns `bit_i`=0 in the ACK phase → `cmd_o` sequence START, 8×WRITE with bits 1,0,1,0,0,1,0,1, READ, STOP; `rxack_o`=0; one `cmd_ack_o`.
- READ with `ack_in_i`=1, bit model feeds 8'h3C → 8×READ then WRITE with `bit_o`=1; `dout_o`=8'h3C; no START or STOP issued.
- STOP only → single STOP command, then `cmd_ack_o`; `busy_o` high for exactly the STOP window plus the DONE cycle.
- `arblost_i` pulsed on the 4th write bit, coincident with `cmd_ack_i` → next cycle IDLE, `cmd_o`=NOP, `i2c_al_o`=`cmd_ack_o`=1 for one cycle; a following transaction completes normally.
- `rst_i` asserted mid-READ → all outputs immediately at reset values; `enable_i` dropped mid-WRITE → IDLE with no `cmd_ack_o`.
- Timeout build, `timeout_i`=16'd20, bit model never acks → `tmo_o`=`cmd_ack_o`=1 on cycle 20 after START; non-timeout build → `busy_o` stays high.
